// File: rtl/pipeline_hazard_pkg.sv
// pipeline_hazard_pkg: forward encodings and memory-wait FSM state type
package pipeline_hazard_pkg;
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_ERR} mem_state_e;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: Execute-stage bypass select for one source operand, M beats W
module fwd_select
  import pipeline_hazard_pkg::*;
#(
  parameter int REG_BITS = 5
) (
  input  logic [REG_BITS-1:0] src,
  input  logic [REG_BITS-1:0] write_reg_m,
  input  logic                reg_write_m,
  input  logic [REG_BITS-1:0] write_reg_w,
  input  logic                reg_write_w,
  output logic [1:0]          sel
);
  logic nz;
  assign nz  = src != '0;
  assign sel = (reg_write_m && nz && src == write_reg_m) ? FWD_MEM :
               (reg_write_w && nz && src == write_reg_w) ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, stall/flush generation, memory-wait FSM,
// MDU busy tracking and a saturating stall counter for a 5-stage pipeline
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int REG_BITS    = 5,
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [REG_BITS-1:0] rs_d,
  input  logic [REG_BITS-1:0] rt_d,
  input  logic [REG_BITS-1:0] rs_e,
  input  logic [REG_BITS-1:0] rt_e,
  input  logic [REG_BITS-1:0] write_reg_e,
  input  logic [REG_BITS-1:0] write_reg_m,
  input  logic [REG_BITS-1:0] write_reg_w,
  input  logic                reg_write_e,
  input  logic                reg_write_m,
  input  logic                reg_write_w,
  input  logic                mem_to_reg_e,
  input  logic                mem_to_reg_m,
  input  logic                branch_d,
  input  logic                jump_d,
  input  logic                taken_d,
  input  logic                mem_req_m,
  input  logic                mem_ready_m,
  input  logic                mdu_start_e,
  input  logic                hilo_use_d,
  input  logic                perf_clr,
  output logic [1:0]          forward_ae,
  output logic [1:0]          forward_be,
  output logic                forward_ad,
  output logic                forward_bd,
  output logic                stall_f,
  output logic                stall_d,
  output logic                stall_e,
  output logic                stall_m,
  output logic                flush_d,
  output logic                flush_e,
  output logic                flush_w,
  output logic                mem_err,
  output logic [CNT_W-1:0]    stall_count
);
  localparam int WT = $clog2(MEM_TIMEOUT + 1);
  mem_state_e state_q, state_d;
  logic [WT-1:0] wait_q, wait_d;
  logic [3:0] mdu_q, mdu_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic load_stall, branch_stall, mdu_stall, mem_stall, hz_stall;
  logic match_e, match_m;

  fwd_select #(.REG_BITS(REG_BITS)) u_fwd_a (
    .src(rs_e), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w), .sel(forward_ae)
  );
  fwd_select #(.REG_BITS(REG_BITS)) u_fwd_b (
    .src(rt_e), .write_reg_m(write_reg_m), .reg_write_m(reg_write_m),
    .write_reg_w(write_reg_w), .reg_write_w(reg_write_w), .sel(forward_be)
  );

  assign forward_ad = reg_write_m && rs_d != '0 && rs_d == write_reg_m;
  assign forward_bd = reg_write_m && rt_d != '0 && rt_d == write_reg_m;

  assign match_e      = write_reg_e != '0 && (rs_d == write_reg_e || rt_d == write_reg_e);
  assign match_m      = write_reg_m != '0 && (rs_d == write_reg_m || rt_d == write_reg_m);
  assign load_stall   = mem_to_reg_e && reg_write_e && match_e;
  assign branch_stall = branch_d && ((reg_write_e && match_e) || (mem_to_reg_m && match_m));
  assign mdu_stall    = hilo_use_d && mdu_q != '0;
  assign mem_stall    = (state_q == MEM_IDLE && mem_req_m && !mem_ready_m) || state_q == MEM_WAIT;
  assign hz_stall     = load_stall || branch_stall || mdu_stall;

  assign stall_f = mem_stall || hz_stall;
  assign stall_d = stall_f;
  assign stall_e = mem_stall;
  assign stall_m = mem_stall;
  assign flush_w = mem_stall;
  assign flush_e = !mem_stall && hz_stall;
  assign flush_d = (jump_d || (branch_d && taken_d)) && !stall_d;
  assign mem_err = err_q;
  assign stall_count = cnt_q;

  always_comb begin
    state_d = state_q;
    wait_d  = '0;
    err_d   = err_q;
    if (state_q == MEM_IDLE) begin
      if (mem_req_m && !mem_ready_m) state_d = MEM_WAIT;
    end else if (state_q == MEM_WAIT) begin
      if (mem_ready_m) state_d = MEM_IDLE;
      else if (wait_q == WT'(MEM_TIMEOUT - 1)) begin
        state_d = MEM_ERR;
        err_d   = 1'b1;
      end else wait_d = wait_q + 1'b1;
    end else if (mem_ready_m) state_d = MEM_IDLE;
    mdu_d = mem_stall ? mdu_q :
            mdu_q != '0 ? mdu_q - 1'b1 :
            mdu_start_e ? 4'(MDU_LAT) : mdu_q;
    cnt_d = perf_clr ? '0 : (stall_f && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= MEM_IDLE;
      wait_q  <= '0;
      mdu_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      mdu_q   <= mdu_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of forwarding, stalls, memory timeout,
// MDU busy window and stall counter with MDU_LAT=4, MEM_TIMEOUT=4, CNT_W=4
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w;
  logic reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m;
  logic branch_d, jump_d, taken_d, mem_req_m, mem_ready_m, mdu_start_e, hilo_use_d, perf_clr;
  logic [1:0] forward_ae, forward_be;
  logic forward_ad, forward_bd, stall_f, stall_d, stall_e, stall_m;
  logic flush_d, flush_e, flush_w, mem_err;
  logic [3:0] stall_count;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_BITS(5), .MDU_LAT(4), .MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .rs_d(rs_d), .rt_d(rt_d), .rs_e(rs_e), .rt_e(rt_e),
    .write_reg_e(write_reg_e), .write_reg_m(write_reg_m), .write_reg_w(write_reg_w),
    .reg_write_e(reg_write_e), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
    .mem_to_reg_e(mem_to_reg_e), .mem_to_reg_m(mem_to_reg_m),
    .branch_d(branch_d), .jump_d(jump_d), .taken_d(taken_d),
    .mem_req_m(mem_req_m), .mem_ready_m(mem_ready_m),
    .mdu_start_e(mdu_start_e), .hilo_use_d(hilo_use_d), .perf_clr(perf_clr),
    .forward_ae(forward_ae), .forward_be(forward_be),
    .forward_ad(forward_ad), .forward_bd(forward_bd),
    .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e), .flush_w(flush_w),
    .mem_err(mem_err), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    {rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w} = '0;
    {reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m} = '0;
    {branch_d, jump_d, taken_d, mem_req_m, mem_ready_m, mdu_start_e, hilo_use_d, perf_clr} = '0;
  endtask

  initial begin
    clr();
    reset_n = 1'b0;
    #3;
    chk("rst_count", 16'(stall_count), 0);
    chk("rst_err", 16'(mem_err), 0);
    chk("rst_stall", 16'(stall_f), 0);
    mem_req_m = 1; #1;
    chk("rst_comb_memstall", 16'(stall_m), 1);
    clr();
    tick(); reset_n = 1'b1;
    rs_e = 3; write_reg_m = 3; reg_write_m = 1; write_reg_w = 3; reg_write_w = 1; #1;
    chk("fwd_a_mem", 16'(forward_ae), 2);
    rs_e = 0; #1;
    chk("fwd_a_zero", 16'(forward_ae), 0);
    rs_e = 3; reg_write_m = 0; #1;
    chk("fwd_a_wb", 16'(forward_ae), 1);
    reg_write_m = 1; rt_e = 3; rs_d = 3; rt_d = 0; #1;
    chk("fwd_b_mem", 16'(forward_be), 2);
    chk("fwd_ad", 16'(forward_ad), 1);
    chk("fwd_bd_zero", 16'(forward_bd), 0);
    clr();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5; rt_d = 5; #1;
    chk("load_stall_f", 16'(stall_f), 1);
    chk("load_stall_d", 16'(stall_d), 1);
    chk("load_flush_e", 16'(flush_e), 1);
    chk("load_stall_e", 16'(stall_e), 0);
    tick();
    clr();
    mem_to_reg_m = 1; reg_write_m = 1; write_reg_m = 5; rt_e = 5; #1;
    chk("load_next_stall", 16'(stall_f), 0);
    chk("load_next_fwd_b", 16'(forward_be), 2);
    chk("load_count", 16'(stall_count), 1);
    clr();
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5; rt_d = 5; perf_clr = 1;
    tick();
    chk("perf_clr_wins", 16'(stall_count), 0);
    clr();
    branch_d = 1; taken_d = 1; reg_write_e = 1; write_reg_e = 7; rs_d = 7; #1;
    chk("br_stall_e", 16'(stall_d), 1);
    chk("br_no_flush_d", 16'(flush_d), 0);
    reg_write_e = 0; #1;
    chk("br_taken_flush_d", 16'(flush_d), 1);
    mem_to_reg_m = 1; write_reg_m = 7; #1;
    chk("br_stall_m", 16'(stall_d), 1);
    clr();
    branch_d = 1; reg_write_e = 1; write_reg_e = 0; #1;
    chk("br_reg0_nostall", 16'(stall_d), 0);
    clr();
    jump_d = 1; #1;
    chk("jump_flush_d", 16'(flush_d), 1);
    clr(); perf_clr = 1;
    tick();
    clr();
    mem_req_m = 1; jump_d = 1; mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5; rt_d = 5; #1;
    chk("mem_stall_m", 16'(stall_m), 1);
    chk("mem_flush_w", 16'(flush_w), 1);
    chk("mem_flush_e_prio", 16'(flush_e), 0);
    chk("mem_flush_d_prio", 16'(flush_d), 0);
    tick();
    clr(); mem_req_m = 1; #1;
    chk("mem_wait_stall_e", 16'(stall_e), 1);
    tick();
    mem_ready_m = 1; #1;
    chk("mem_ready_cycle", 16'(stall_m), 1);
    tick();
    clr(); #1;
    chk("mem_done", 16'(stall_m), 0);
    chk("mem_count3", 16'(stall_count), 3);
    mem_req_m = 1;
    tick();
    repeat (3) tick();
    chk("tmo_not_yet", 16'(mem_err), 0);
    chk("tmo_wait_stall", 16'(stall_m), 1);
    tick();
    chk("tmo_err", 16'(mem_err), 1);
    chk("tmo_err_nostall", 16'(stall_m), 0);
    mem_ready_m = 1;
    tick();
    clr(); #1;
    chk("tmo_sticky", 16'(mem_err), 1);
    reset_n = 1'b0; #1;
    chk("tmo_reset_clears", 16'(mem_err), 0);
    tick(); reset_n = 1'b1;
    mem_to_reg_e = 1; reg_write_e = 1; write_reg_e = 5; rt_d = 5;
    repeat (14) tick();
    chk("sat_14", 16'(stall_count), 14);
    tick();
    chk("sat_15", 16'(stall_count), 15);
    repeat (2) tick();
    chk("sat_hold", 16'(stall_count), 15);
    clr(); perf_clr = 1;
    tick();
    clr(); mdu_start_e = 1; hilo_use_d = 1; #1;
    chk("mdu_idle", 16'(stall_f), 0);
    tick();
    mdu_start_e = 0; #1;
    chk("mdu_c1", 16'(stall_f), 1);
    tick();
    mem_req_m = 1; #1;
    chk("mdu_mem_c2", 16'(stall_m), 1);
    tick();
    mem_ready_m = 1;
    tick();
    mem_req_m = 0; mem_ready_m = 0; #1;
    chk("mdu_c4", 16'(stall_f), 1);
    chk("mdu_c4_nomem", 16'(stall_m), 0);
    tick();
    mdu_start_e = 1;
    tick();
    mdu_start_e = 0; #1;
    chk("mdu_c6", 16'(stall_f), 1);
    tick();
    chk("mdu_done", 16'(stall_f), 0);
    chk("mdu_count6", 16'(stall_count), 6);
    clr(); mdu_start_e = 1;
    tick();
    clr(); hilo_use_d = 1; #1;
    chk("rst_mdu_pre", 16'(stall_f), 1);
    reset_n = 1'b0; #1;
    chk("rst_mdu_drop", 16'(stall_f), 0);
    tick(); reset_n = 1'b1; #1;
    chk("rst_mdu_after", 16'(stall_f), 0);
    clr(); mem_req_m = 1;
    tick();
    mem_req_m = 0; #1;
    chk("rst_wait_pre", 16'(stall_m), 1);
    reset_n = 1'b0; #1;
    chk("rst_wait_drop", 16'(stall_m), 0);
    tick(); reset_n = 1'b1; #1;
    chk("rst_wait_after", 16'(stall_m), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
